cv_spdma: RTL

Sprite-attribute DMA engine that sits directly upstream of the sprite memory in `cv_csmem`. On a frame trigger it copies a block of 64-bit sprite entries from a staging buffer into sprite RAM through the 32-bit `ps_s_*` write port, normally during vertical blanking. With this block, software updates the staging buffer at any time and the sprite table seen by `cv_sp` changes only at a frame boundary.

---
 rtl/cv_spdma_if.sv | 23 ++
 rtl/cv_spdma.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cv_spdma_if.sv
// cv_spdma bus bundle: staging-buffer read port plus sprite RAM write port.
// master = DMA engine side, slave = memory side.
interface cv_spdma_if #(
  parameter int CNT_W = 10
);
  logic [CNT_W-1:0] src_addr;
  logic             src_ren;
  logic [63:0]      src_dout;
  logic [18:0]      ps_s_addr;
  logic [31:0]      ps_s_din;
  logic [3:0]       ps_s_we;
  logic             ps_s_en;

  modport master (
    output src_addr, src_ren, ps_s_addr, ps_s_din, ps_s_we, ps_s_en,
    input  src_dout
  );

  modport slave (
    input  src_addr, src_ren, ps_s_addr, ps_s_din, ps_s_we, ps_s_en,
    output src_dout
  );
endinterface

// File: rtl/cv_spdma.sv
// cv_spdma: sprite-attribute DMA. On a trigger, copies `count` 64-bit entries
// from the staging buffer into sprite RAM as two 32-bit writes each (low word
// first), 3 cycles per entry: READ -> WLO -> WHI.
// Optional feature macro: CV_SPDMA_ABORT_EN (abort sampled in READ; an entry is
// always written completely or not at all).
module cv_spdma #(
  parameter logic [18:0] DST_BASE = 19'h00000,
  parameter int          CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             auto_en,
  input  logic             v_end,
  input  logic             abort,
  input  logic [CNT_W-1:0] count,
  cv_spdma_if.master       bus,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             overrun,
  output logic [CNT_W:0]   xfer_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WLO, S_WHI} state_t;

  state_t           st, nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [18:0]      addr_q;
  logic [31:0]      lo_q;   // last word presented on ps_s_din
  logic [31:0]      hi_q;   // high word of the entry in flight
  logic             trig;
  logic             last;
  logic             abort_hit;
  logic [18:0]      off;

  assign trig = start | (auto_en & v_end);
  assign last = (xfer_cnt + (CNT_W+1)'(1)) == {1'b0, cnt_q};
  assign off  = 19'({xfer_cnt, 3'b000});
  assign busy = (st != S_IDLE);

`ifdef CV_SPDMA_ABORT_EN
  // abort only matters in READ, before the entry's read is issued
  assign abort_hit = abort & (st == S_READ);
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_hit    = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!reset) st <= S_IDLE;
    else        st <= nxt;
  end

  // next state and per-state bus strobes
  always_comb begin
    nxt           = st;
    bus.src_ren   = 1'b0;
    bus.src_addr  = xfer_cnt[CNT_W-1:0];
    bus.ps_s_en   = 1'b0;
    bus.ps_s_we   = 4'h0;
    bus.ps_s_addr = addr_q;
    bus.ps_s_din  = lo_q;
    case (st)
      S_IDLE: if (trig && count != '0) nxt = S_READ;
      S_READ: begin
        bus.src_ren = ~abort_hit;
        nxt         = abort_hit ? S_IDLE : S_WLO;
      end
      S_WLO: begin
        bus.ps_s_en  = 1'b1;
        bus.ps_s_we  = 4'hF;
        bus.ps_s_din = bus.src_dout[31:0];   // BRAM data arrives this cycle
        nxt          = S_WHI;
      end
      S_WHI: begin
        bus.ps_s_en  = 1'b1;
        bus.ps_s_we  = 4'hF;
        bus.ps_s_din = hi_q;
        nxt          = last ? S_IDLE : S_READ;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // datapath: count latch, progress counter, address/data holding, flags
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      xfer_cnt <= '0;
      addr_q   <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (st)
        S_IDLE: if (trig) begin
          cnt_q    <= count;
          xfer_cnt <= '0;
          overrun  <= 1'b0;
          if (count == '0) done <= 1'b1;
        end
        S_READ: begin
          if (abort_hit) done   <= 1'b1;
          else           addr_q <= DST_BASE + off;
        end
        S_WLO: begin
          lo_q   <= bus.src_dout[31:0];
          hi_q   <= bus.src_dout[63:32];
          addr_q <= addr_q + 19'd4;
        end
        S_WHI: begin
          lo_q     <= hi_q;
          xfer_cnt <= xfer_cnt + (CNT_W+1)'(1);
          if (last) done <= 1'b1;
        end
        default: ;
      endcase
      if (trig && st != S_IDLE) overrun <= 1'b1;
    end
  end

`ifdef CV_SPDMA_ABORT_EN
  logic abt_q;
  assign aborted = abt_q;

  // aborted: set by an abort in READ, cleared by the next accepted trigger
  always_ff @(posedge clk) begin
    if (!reset)                 abt_q <= 1'b0;
    else if (st == S_IDLE && trig) abt_q <= 1'b0;
    else if (abort_hit)         abt_q <= 1'b1;
  end
`else
  assign aborted = 1'b0;
`endif

endmodule
